sal_cmd_sched: RTL and testbench
================================

Name: sal_cmd_sched

Overview:
- Per-channel DRAM command scheduler for the DDR2 controller.
- Collects ACT/RD/WR/PRE/REF requests from NUM_BANKS bank controllers and grants at most one per cycle; grants are combinational, in the same cycle as the request.
- Enforces inter-bank timing (tRRD, tCCD, tWTR, tRTW). Per-bank timing stays in the bank controllers.
- Registers the granted command toward the PHY command encoder.

Parameters:
NUM_BANKS, 4, number of bank controllers served (power of 2)
BA_WIDTH, 2, log2(NUM_BANKS)
RA_WIDTH, 14, row address width
CA_WIDTH, 10, column address width
TW, 4, width of each inter-bank timing counter and timing input

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
act_req_i  in  NUM_BANKS  per-bank activate request
rd_req_i  in  NUM_BANKS  per-bank read request
wr_req_i  in  NUM_BANKS  per-bank write request
pre_req_i  in  NUM_BANKS  per-bank precharge request
ref_req_i  in  NUM_BANKS  per-bank refresh request
ra_i  in  NUM_BANKS*RA_WIDTH  per-bank row address, bank b at [b*RA_WIDTH +: RA_WIDTH]
ca_i  in  NUM_BANKS*CA_WIDTH  per-bank column address, same packing
t_rrd_i, t_ccd_i, t_wtr_i, t_rtw_i  in  TW each  timing values in cycles, quasi-static
act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o  out  NUM_BANKS each  one-hot grants, combinational
cmd_valid_o  out  1  registered command valid
cmd_o  out  3  registered command code (pkg enum)
cmd_ba_o  out  BA_WIDTH  registered bank address
cmd_addr_o  out  max(RA_WIDTH,CA_WIDTH)  registered address: row for ACT, column for RD/WR, zero-extended

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk.
  - While reset is asserted, all counters are 0, rr_ptr is 0, cmd_valid_o is 0, cmd_o is CMD_NOP, and cmd_ba_o and cmd_addr_o are 0.
  - Grants are forced to 0 while rst_n is low.
- At most one bit is set across all five grant vectors in any cycle.
- Class priority, highest first: REF > PRE > CAS (RD/WR) > ACT.
  - A class competes only if at least one bank in it is eligible.
- Within a class, round-robin arbitration starts at rr_ptr. After any grant, rr_ptr becomes (granted bank + 1) mod NUM_BANKS.
- Eligibility:
  - ACT requires rrd_cnt==0.
  - RD requires ccd_cnt==0 and wtr_cnt==0.
  - WR requires ccd_cnt==0 and rtw_cnt==0.
  - PRE and REF are always eligible.
  - An ineligible request is not granted. It must not block a lower-priority class.
- A bank asserting several request types in one cycle is arbitrated by its highest-priority eligible type only.
- Counters:
  - On a grant, the relevant counter loads (T==0 ? 0 : T-1). It decrements by 1 per cycle and saturates at 0.
  - Effect: after a grant in cycle N, the next dependent command is allowed no earlier than cycle N+max(T,1).
  - ACT grant loads rrd_cnt.
  - RD grant loads ccd_cnt and rtw_cnt.
  - WR grant loads ccd_cnt and wtr_cnt.
- Output register: captures the granted command, bank and address at the clock edge. Latency is 1 cycle from grant to cmd_valid_o. With no grant, cmd_valid_o=0 and cmd_o=CMD_NOP.
- Address selection: ACT drives ra_i of the granted bank; RD and WR drive ca_i. PRE and REF drive address 0.
- A request deasserted in the same cycle is simply not seen. No state is kept per request.
- Reset mid-operation: a pending output command is dropped and all timing counters are cleared.

Decomposition:
- Package sal_sched_pkg holds:
  - cmd_t enum: CMD_NOP=0, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF.
  - Class priority constants.
- Sub-module sal_rr_arb, parameterised on N:
  - Inputs: req[N], ptr.
  - Outputs: one-hot gnt[N], any_gnt.
  - Instantiated once per class (four instances); sal_cmd_sched selects the winning class.
- Inter-bank counters reuse the team's existing SAL_TIMING_CNTR only if its load semantics match the T-1 rule above. Otherwise they are inline logic.

Test Plan:
- ACT on banks 0 and 1 in the same cycle, t_rrd=3, rr_ptr=0 -> act_gnt_o=0001 in cycle N, bank 1 granted in cycle N+3; cmd_o=ACT with cmd_ba_o=0 in cycle N+1 and with cmd_ba_o=1 in cycle N+4.
- REF on bank 2 together with RD on bank 0 -> ref_gnt_o=0100; RD on bank 0 granted the next cycle.
- WR on bank 1 granted in cycle N, t_wtr=5, t_ccd=2, then RD on bank 3 held -> RD granted no earlier than cycle N+5; ACT on bank 0 raised at N+1 is granted at N+1, not blocked.
- RD requested continuously on all 4 banks, t_ccd=1 -> grants rotate 0,1,2,3,0 on consecutive cycles with no gaps.
- All timing inputs 0 -> back-to-back RD and WR on consecutive cycles are allowed.
- Reset asserted 1 cycle after an ACT grant -> cmd_valid_o=0 the next cycle and all counters 0; after release, ACT is granted immediately with rr_ptr=0.

Source files
------------

// File: rtl/sal_cmd_sched_pkg.sv
// sal_sched_pkg: shared types for the per-channel DRAM command scheduler.
// Ports: none (package). Provides the command code enum and the class
// priority encoding used when choosing between the four arbiters.
package sal_sched_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_t;

  // Arbitration classes; a larger encoding wins over a smaller one.
  typedef enum logic [1:0] {
    CLS_ACT = 2'd0,
    CLS_CAS = 2'd1,
    CLS_PRE = 2'd2,
    CLS_REF = 2'd3
  } cls_t;

endpackage

// File: rtl/sal_cmd_sched_if.sv
// sal_cmd_sched_if: bank-controller/PHY side bus of the command scheduler.
// Ports: per-bank request vectors, packed row/column addresses, timing values,
// one-hot grants and the registered command toward the PHY encoder.
interface sal_cmd_sched_if
  import sal_sched_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int BA_WIDTH  = 2,
  parameter int RA_WIDTH  = 14,
  parameter int CA_WIDTH  = 10,
  parameter int TW        = 4,
  parameter int AW        = (RA_WIDTH > CA_WIDTH) ? RA_WIDTH : CA_WIDTH
);
  logic [NUM_BANKS-1:0]          act_req_i;
  logic [NUM_BANKS-1:0]          rd_req_i;
  logic [NUM_BANKS-1:0]          wr_req_i;
  logic [NUM_BANKS-1:0]          pre_req_i;
  logic [NUM_BANKS-1:0]          ref_req_i;
  logic [NUM_BANKS*RA_WIDTH-1:0] ra_i;
  logic [NUM_BANKS*CA_WIDTH-1:0] ca_i;
  logic [TW-1:0]                 t_rrd_i;
  logic [TW-1:0]                 t_ccd_i;
  logic [TW-1:0]                 t_wtr_i;
  logic [TW-1:0]                 t_rtw_i;
  logic [NUM_BANKS-1:0]          act_gnt_o;
  logic [NUM_BANKS-1:0]          rd_gnt_o;
  logic [NUM_BANKS-1:0]          wr_gnt_o;
  logic [NUM_BANKS-1:0]          pre_gnt_o;
  logic [NUM_BANKS-1:0]          ref_gnt_o;
  logic                          cmd_valid_o;
  cmd_t                          cmd_o;
  logic [BA_WIDTH-1:0]           cmd_ba_o;
  logic [AW-1:0]                 cmd_addr_o;

  // Bank controllers / PHY side.
  modport master (
    output act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i, ra_i, ca_i,
           t_rrd_i, t_ccd_i, t_wtr_i, t_rtw_i,
    input  act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o,
           cmd_valid_o, cmd_o, cmd_ba_o, cmd_addr_o
  );

  // Scheduler side.
  modport slave (
    input  act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i, ra_i, ca_i,
           t_rrd_i, t_ccd_i, t_wtr_i, t_rtw_i,
    output act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o,
           cmd_valid_o, cmd_o, cmd_ba_o, cmd_addr_o
  );

endinterface

// File: rtl/sal_cmd_sched_rr_arb.sv
// sal_rr_arb: combinational round-robin arbiter, search starts at ptr.
// Ports: req[N] requests, ptr start index; gnt[N] one-hot grant, any_gnt.
// N must be a power of two so the index wraps by truncation.
module sal_rr_arb #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic         any_gnt
);

  logic [W-1:0] idx;

  always_comb begin
    gnt     = '0;
    any_gnt = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + W'(i);
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        any_gnt  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sal_cmd_sched.sv
// sal_cmd_sched: per-channel DRAM command scheduler, one grant per cycle.
// Ports: clk, rst_n (sync, active-low); bus (slave) carries requests,
// addresses, inter-bank timing, combinational grants and the registered command.
module sal_cmd_sched
  import sal_sched_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int BA_WIDTH  = 2,
  parameter int RA_WIDTH  = 14,
  parameter int CA_WIDTH  = 10,
  parameter int TW        = 4
) (
  input logic            clk,
  input logic            rst_n,
  sal_cmd_sched_if.slave bus
);

  localparam int AW = (RA_WIDTH > CA_WIDTH) ? RA_WIDTH : CA_WIDTH;

  logic [BA_WIDTH-1:0]  rr_ptr;
  logic [TW-1:0]        rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
  logic                 act_ok, rd_ok, wr_ok;
  logic [NUM_BANKS-1:0] rd_elig, wr_elig, hi_req;
  logic [NUM_BANKS-1:0] ref_req, pre_req, cas_req, act_req;
  logic [NUM_BANKS-1:0] ref_gnt, pre_gnt, cas_gnt, act_gnt;
  logic                 ref_any, pre_any, cas_any, act_any;
  logic [NUM_BANKS-1:0] gnt_vec;
  logic                 gnt_any;
  cls_t                 gnt_cls;
  cmd_t                 gnt_cmd;
  logic [BA_WIDTH-1:0]  gnt_idx;
  logic [AW-1:0]        gnt_addr;

  function automatic logic [TW-1:0] cnt_load(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  function automatic logic [TW-1:0] cnt_dec(input logic [TW-1:0] c);
    return (c == '0) ? '0 : c - TW'(1);
  endfunction

  assign act_ok = (rrd_cnt == '0);
  assign rd_ok  = (ccd_cnt == '0) && (wtr_cnt == '0);
  assign wr_ok  = (ccd_cnt == '0) && (rtw_cnt == '0);

  // Each bank competes only with its highest-priority eligible request, so
  // lower classes are masked by any eligible higher-class request of that bank.
  assign rd_elig = bus.rd_req_i & {NUM_BANKS{rd_ok}};
  assign wr_elig = bus.wr_req_i & {NUM_BANKS{wr_ok}};
  assign hi_req  = bus.ref_req_i | bus.pre_req_i;
  assign ref_req = bus.ref_req_i;
  assign pre_req = bus.pre_req_i & ~bus.ref_req_i;
  assign cas_req = (rd_elig | wr_elig) & ~hi_req;
  assign act_req = bus.act_req_i & {NUM_BANKS{act_ok}} & ~hi_req & ~rd_elig & ~wr_elig;

  sal_rr_arb #(.N(NUM_BANKS)) u_arb_ref (.req(ref_req), .ptr(rr_ptr), .gnt(ref_gnt), .any_gnt(ref_any));
  sal_rr_arb #(.N(NUM_BANKS)) u_arb_pre (.req(pre_req), .ptr(rr_ptr), .gnt(pre_gnt), .any_gnt(pre_any));
  sal_rr_arb #(.N(NUM_BANKS)) u_arb_cas (.req(cas_req), .ptr(rr_ptr), .gnt(cas_gnt), .any_gnt(cas_any));
  sal_rr_arb #(.N(NUM_BANKS)) u_arb_act (.req(act_req), .ptr(rr_ptr), .gnt(act_gnt), .any_gnt(act_any));

  // Class selection; nothing is granted while reset is held.
  always_comb begin
    gnt_any = 1'b0;
    gnt_cls = CLS_ACT;
    if (rst_n) begin
      gnt_any = 1'b1;
      if (ref_any)      gnt_cls = CLS_REF;
      else if (pre_any) gnt_cls = CLS_PRE;
      else if (cas_any) gnt_cls = CLS_CAS;
      else if (act_any) gnt_cls = CLS_ACT;
      else              gnt_any = 1'b0;
    end
  end

  always_comb begin
    bus.act_gnt_o = '0;
    bus.rd_gnt_o  = '0;
    bus.wr_gnt_o  = '0;
    bus.pre_gnt_o = '0;
    bus.ref_gnt_o = '0;
    gnt_vec       = '0;
    gnt_cmd       = CMD_NOP;
    if (gnt_any) begin
      case (gnt_cls)
        CLS_REF: begin bus.ref_gnt_o = ref_gnt; gnt_vec = ref_gnt; gnt_cmd = CMD_REF; end
        CLS_PRE: begin bus.pre_gnt_o = pre_gnt; gnt_vec = pre_gnt; gnt_cmd = CMD_PRE; end
        CLS_CAS: begin
          // A bank with both RD and WR eligible issues the read.
          bus.rd_gnt_o = cas_gnt & rd_elig;
          bus.wr_gnt_o = cas_gnt & ~rd_elig;
          gnt_vec      = cas_gnt;
          gnt_cmd      = ((cas_gnt & rd_elig) != '0) ? CMD_RD : CMD_WR;
        end
        default: begin bus.act_gnt_o = act_gnt; gnt_vec = act_gnt; gnt_cmd = CMD_ACT; end
      endcase
    end
  end

  always_comb begin
    gnt_idx  = '0;
    gnt_addr = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (gnt_vec[b]) begin
        gnt_idx = BA_WIDTH'(b);
        if (gnt_cmd == CMD_ACT)
          gnt_addr = AW'(bus.ra_i[b*RA_WIDTH +: RA_WIDTH]);
        else if (gnt_cmd == CMD_RD || gnt_cmd == CMD_WR)
          gnt_addr = AW'(bus.ca_i[b*CA_WIDTH +: CA_WIDTH]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr          <= '0;
      rrd_cnt         <= '0;
      ccd_cnt         <= '0;
      wtr_cnt         <= '0;
      rtw_cnt         <= '0;
      bus.cmd_valid_o <= 1'b0;
      bus.cmd_o       <= CMD_NOP;
      bus.cmd_ba_o    <= '0;
      bus.cmd_addr_o  <= '0;
    end else begin
      if (gnt_any) rr_ptr <= gnt_idx + BA_WIDTH'(1);
      rrd_cnt <= (gnt_cmd == CMD_ACT) ? cnt_load(bus.t_rrd_i) : cnt_dec(rrd_cnt);
      ccd_cnt <= (gnt_cmd == CMD_RD || gnt_cmd == CMD_WR) ? cnt_load(bus.t_ccd_i) : cnt_dec(ccd_cnt);
      rtw_cnt <= (gnt_cmd == CMD_RD) ? cnt_load(bus.t_rtw_i) : cnt_dec(rtw_cnt);
      wtr_cnt <= (gnt_cmd == CMD_WR) ? cnt_load(bus.t_wtr_i) : cnt_dec(wtr_cnt);
      bus.cmd_valid_o <= gnt_any;
      bus.cmd_o       <= gnt_cmd;
      bus.cmd_ba_o    <= gnt_idx;
      bus.cmd_addr_o  <= gnt_addr;
    end
  end

endmodule

// File: tb/tb_sal_cmd_sched.sv
// tb_sal_cmd_sched: directed bench for sal_cmd_sched.
// Ports: none. Drives the scheduler bus one cycle at a time and checks
// grants and the registered command against hand-computed values.
module tb_sal_cmd_sched;
  import sal_sched_pkg::*;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   chk_cnt;

  sal_cmd_sched_if #(.NUM_BANKS(4), .BA_WIDTH(2), .RA_WIDTH(14), .CA_WIDTH(10), .TW(4)) bus ();

  sal_cmd_sched #(.NUM_BANKS(4), .BA_WIDTH(2), .RA_WIDTH(14), .CA_WIDTH(10), .TW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.act_req_i = '0;
    bus.rd_req_i  = '0;
    bus.wr_req_i  = '0;
    bus.pre_req_i = '0;
    bus.ref_req_i = '0;
  endtask

  task automatic set_timing(input logic [3:0] rrd, ccd, wtr, rtw);
    bus.t_rrd_i = rrd;
    bus.t_ccd_i = ccd;
    bus.t_wtr_i = wtr;
    bus.t_rtw_i = rtw;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_reqs();
    rst_n = 1'b0;
    bus.act_req_i = 4'b1111;
    bus.ref_req_i = 4'b0010;
    step();
    step();
    @(negedge clk);
    chk_cnt++;
    if (bus.act_gnt_o !== 4'b0000 || bus.ref_gnt_o !== 4'b0000)
      $display("FAIL reset_gnt: act=%b ref=%b want 0000/0000", bus.act_gnt_o, bus.ref_gnt_o);
    else pass_cnt++;
    chk_cnt++;
    if (bus.cmd_valid_o !== 1'b0 || bus.cmd_o !== CMD_NOP)
      $display("FAIL reset_cmd: valid=%b cmd=%0d want 0/%0d", bus.cmd_valid_o, bus.cmd_o, CMD_NOP);
    else pass_cnt++;
    chk_cnt++;
    if (bus.cmd_ba_o !== 2'd0 || bus.cmd_addr_o !== 14'd0)
      $display("FAIL reset_addr: ba=%0d addr=%h want 0/0", bus.cmd_ba_o, bus.cmd_addr_o);
    else pass_cnt++;
    clear_reqs();
    rst_n = 1'b1;
  endtask

  task automatic test_act_rrd();
    do_reset();
    set_timing(4'd3, 4'd1, 4'd1, 4'd1);
    bus.ra_i = {14'h0, 14'h0, 14'h0155, 14'h00AA};
    bus.act_req_i = 4'b0011;
    @(negedge clk);
    chk_cnt++;
    if (bus.act_gnt_o !== 4'b0001) $display("FAIL act_first: got %b want 0001", bus.act_gnt_o);
    else pass_cnt++;
    step();
    bus.act_req_i = 4'b0010;
    @(negedge clk);
    chk_cnt++;
    if (bus.cmd_valid_o !== 1'b1 || bus.cmd_o !== CMD_ACT || bus.cmd_ba_o !== 2'd0 || bus.cmd_addr_o !== 14'h00AA)
      $display("FAIL act_cmd0: valid=%b cmd=%0d ba=%0d addr=%h want 1/%0d/0/00aa",
               bus.cmd_valid_o, bus.cmd_o, bus.cmd_ba_o, bus.cmd_addr_o, CMD_ACT);
    else pass_cnt++;
    for (int k = 1; k <= 2; k++) begin
      if (k == 2) step();
      if (k == 2) @(negedge clk);
      chk_cnt++;
      if (bus.act_gnt_o !== 4'b0000) $display("FAIL act_rrd_hold: N+%0d got %b want 0000", k, bus.act_gnt_o);
      else pass_cnt++;
    end
    step();
    @(negedge clk);
    chk_cnt++;
    if (bus.act_gnt_o !== 4'b0010) $display("FAIL act_second: got %b want 0010", bus.act_gnt_o);
    else pass_cnt++;
    step();
    clear_reqs();
    @(negedge clk);
    chk_cnt++;
    if (bus.cmd_valid_o !== 1'b1 || bus.cmd_o !== CMD_ACT || bus.cmd_ba_o !== 2'd1 || bus.cmd_addr_o !== 14'h0155)
      $display("FAIL act_cmd1: valid=%b cmd=%0d ba=%0d addr=%h want 1/%0d/1/0155",
               bus.cmd_valid_o, bus.cmd_o, bus.cmd_ba_o, bus.cmd_addr_o, CMD_ACT);
    else pass_cnt++;
  endtask

  task automatic test_ref_priority();
    do_reset();
    set_timing(4'd1, 4'd1, 4'd1, 4'd1);
    bus.ca_i = {10'h0, 10'h0, 10'h0, 10'h123};
    bus.ref_req_i = 4'b0100;
    bus.rd_req_i  = 4'b0001;
    @(negedge clk);
    chk_cnt++;
    if (bus.ref_gnt_o !== 4'b0100 || bus.rd_gnt_o !== 4'b0000)
      $display("FAIL ref_over_rd: ref=%b rd=%b want 0100/0000", bus.ref_gnt_o, bus.rd_gnt_o);
    else pass_cnt++;
    step();
    bus.ref_req_i = 4'b0000;
    @(negedge clk);
    chk_cnt++;
    if (bus.rd_gnt_o !== 4'b0001) $display("FAIL rd_after_ref: got %b want 0001", bus.rd_gnt_o);
    else pass_cnt++;
    chk_cnt++;
    if (bus.cmd_o !== CMD_REF || bus.cmd_ba_o !== 2'd2 || bus.cmd_addr_o !== 14'd0)
      $display("FAIL ref_cmd: cmd=%0d ba=%0d addr=%h want %0d/2/0000", bus.cmd_o, bus.cmd_ba_o, bus.cmd_addr_o, CMD_REF);
    else pass_cnt++;
    step();
    clear_reqs();
    @(negedge clk);
    chk_cnt++;
    if (bus.cmd_o !== CMD_RD || bus.cmd_ba_o !== 2'd0 || bus.cmd_addr_o !== 14'h0123)
      $display("FAIL rd_cmd: cmd=%0d ba=%0d addr=%h want %0d/0/0123", bus.cmd_o, bus.cmd_ba_o, bus.cmd_addr_o, CMD_RD);
    else pass_cnt++;
  endtask

  task automatic test_wtr();
    do_reset();
    set_timing(4'd1, 4'd2, 4'd5, 4'd1);
    bus.ca_i = {10'h0, 10'h0, 10'h2C3, 10'h0};
    bus.wr_req_i = 4'b0010;
    bus.rd_req_i = 4'b1000;
    @(negedge clk);
    chk_cnt++;
    if (bus.wr_gnt_o !== 4'b0010 || bus.rd_gnt_o !== 4'b0000)
      $display("FAIL wr_first: wr=%b rd=%b want 0010/0000", bus.wr_gnt_o, bus.rd_gnt_o);
    else pass_cnt++;
    step();
    bus.wr_req_i  = 4'b0000;
    bus.act_req_i = 4'b0001;
    @(negedge clk);
    chk_cnt++;
    if (bus.act_gnt_o !== 4'b0001 || bus.rd_gnt_o !== 4'b0000)
      $display("FAIL act_not_blocked: act=%b rd=%b want 0001/0000", bus.act_gnt_o, bus.rd_gnt_o);
    else pass_cnt++;
    chk_cnt++;
    if (bus.cmd_o !== CMD_WR || bus.cmd_ba_o !== 2'd1 || bus.cmd_addr_o !== 14'h02C3)
      $display("FAIL wr_cmd: cmd=%0d ba=%0d addr=%h want %0d/1/02c3", bus.cmd_o, bus.cmd_ba_o, bus.cmd_addr_o, CMD_WR);
    else pass_cnt++;
    bus.act_req_i = 4'b0000;
    for (int k = 2; k <= 4; k++) begin
      step();
      @(negedge clk);
      chk_cnt++;
      if (bus.rd_gnt_o !== 4'b0000) $display("FAIL rd_wtr_hold: N+%0d got %b want 0000", k, bus.rd_gnt_o);
      else pass_cnt++;
    end
    step();
    @(negedge clk);
    chk_cnt++;
    if (bus.rd_gnt_o !== 4'b1000) $display("FAIL rd_after_wtr: got %b want 1000", bus.rd_gnt_o);
    else pass_cnt++;
    step();
    clear_reqs();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_gnt [5];
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    set_timing(4'd1, 4'd1, 4'd1, 4'd1);
    bus.rd_req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      @(negedge clk);
      chk_cnt++;
      if (bus.rd_gnt_o !== exp_gnt[k]) $display("FAIL rd_rotate: cycle %0d got %b want %b", k, bus.rd_gnt_o, exp_gnt[k]);
      else pass_cnt++;
    end
    step();
    clear_reqs();
  endtask

  task automatic test_zero_timing();
    do_reset();
    set_timing(4'd0, 4'd0, 4'd0, 4'd0);
    bus.rd_req_i = 4'b0001;
    @(negedge clk);
    chk_cnt++;
    if (bus.rd_gnt_o !== 4'b0001) $display("FAIL zero_rd0: got %b want 0001", bus.rd_gnt_o);
    else pass_cnt++;
    step();
    bus.rd_req_i = 4'b0000;
    bus.wr_req_i = 4'b0010;
    @(negedge clk);
    chk_cnt++;
    if (bus.wr_gnt_o !== 4'b0010) $display("FAIL zero_wr1: got %b want 0010", bus.wr_gnt_o);
    else pass_cnt++;
    step();
    bus.wr_req_i = 4'b0000;
    bus.rd_req_i = 4'b0100;
    @(negedge clk);
    chk_cnt++;
    if (bus.rd_gnt_o !== 4'b0100) $display("FAIL zero_rd2: got %b want 0100", bus.rd_gnt_o);
    else pass_cnt++;
    step();
    clear_reqs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_timing(4'd3, 4'd1, 4'd1, 4'd1);
    bus.act_req_i = 4'b0100;
    @(negedge clk);
    chk_cnt++;
    if (bus.act_gnt_o !== 4'b0100) $display("FAIL mid_act: got %b want 0100", bus.act_gnt_o);
    else pass_cnt++;
    step();
    rst_n = 1'b0;
    bus.act_req_i = 4'b1001;
    @(negedge clk);
    chk_cnt++;
    if (bus.act_gnt_o !== 4'b0000) $display("FAIL mid_gnt_in_reset: got %b want 0000", bus.act_gnt_o);
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (bus.cmd_valid_o !== 1'b0) $display("FAIL mid_valid_drop: got %b want 0", bus.cmd_valid_o);
    else pass_cnt++;
    chk_cnt++;
    if (bus.act_gnt_o !== 4'b0001) $display("FAIL mid_act_after: got %b want 0001", bus.act_gnt_o);
    else pass_cnt++;
    step();
    clear_reqs();
    @(negedge clk);
    chk_cnt++;
    if (bus.cmd_valid_o !== 1'b1 || bus.cmd_o !== CMD_ACT || bus.cmd_ba_o !== 2'd0)
      $display("FAIL mid_cmd: valid=%b cmd=%0d ba=%0d want 1/%0d/0", bus.cmd_valid_o, bus.cmd_o, bus.cmd_ba_o, CMD_ACT);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    rst_n    = 1'b0;
    clear_reqs();
    bus.ra_i = '0;
    bus.ca_i = '0;
    set_timing(4'd1, 4'd1, 4'd1, 4'd1);
    test_reset();
    test_act_rrd();
    test_ref_priority();
    test_wtr();
    test_back_to_back();
    test_zero_timing();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
